cache_memory_responder: RTL
===========================

CACHE_MEMORY_RESPONDER -- requirements
Module: cache_memory_responder

Interface
REQ-001 Parameter DWIDTH, default 16, data word width.
REQ-002 Parameter ADDR_WIDTH, default 16, request address width.
REQ-003 Parameter MEM_ADDR_BITS, default 8, log2 of backing-store depth, at most ADDR_WIDTH.
REQ-004 Parameter READ_LATENCY, default 1, cycles from request handshake to response, at least 1.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 Port clk, input, 1, sole clock, rising edge.
REQ-007 Port reset, input, 1, asynchronous active-high reset.
REQ-008 Port addr_in_valid, input, 1, cache miss request valid (driven from cache addr_out_valid).
REQ-009 Port addr_in, input, ADDR_WIDTH, requested address (from cache addr_out).
REQ-010 Port addr_in_ready, output, 1, responder can accept a request (to cache addr_out_ready).
REQ-011 Port data_out, output, DWIDTH, response word (to cache data_in).
REQ-012 Port data_out_valid, output, 1, one-cycle response strobe.
REQ-013 Port wr_en, input, 1, backing-store preload write enable.
REQ-014 Port wr_addr, input, ADDR_WIDTH, preload address.
REQ-015 Port wr_data, input, DWIDTH, preload data.

Function
REQ-016 The backing store SHALL hold 2^MEM_ADDR_BITS words, indexed by address bits [MEM_ADDR_BITS-1:0], with upper address bits ignored.
REQ-017 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-018 addr_in_ready SHALL be 1 only in IDLE.
REQ-019 A handshake SHALL occur on a rising edge where addr_in_valid and addr_in_ready are both 1.
REQ-020 On a handshake the block SHALL sample the word at addr_in's index into a holding register, with the pre-write value if wr_en targets the same index on that edge.
REQ-021 On a handshake the FSM SHALL go to RESP if READ_LATENCY is 1, and otherwise to WAIT with the latency counter loaded with READ_LATENCY-1.
REQ-022 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL go to RESP when the counter reaches 1.
REQ-023 data_out_valid SHALL be 1 exactly in RESP, which always lasts one cycle and then returns to IDLE.
REQ-024 The response SHALL therefore appear READ_LATENCY cycles after the handshake edge, with no backpressure.
REQ-025 data_out SHALL present the holding register and SHALL hold its value until the next response.
REQ-026 Writes SHALL be accepted on every edge with wr_en=1 in any state.
REQ-027 Writes during WAIT or RESP SHALL NOT alter an in-flight response.
REQ-028 With addr_in_valid held at 1, requests SHALL be accepted once every READ_LATENCY+1 cycles.
REQ-029 addr_in_valid while not in IDLE SHALL be ignored, with no queuing.
REQ-030 The latency counter width SHALL be $clog2(READ_LATENCY+1).

Reset
REQ-031 While reset is 1, the FSM SHALL be in IDLE, the counter at 0, data_out at 0, data_out_valid at 0 and addr_in_ready at 1.
REQ-032 Reset SHALL NOT clear backing-store contents.
REQ-033 Reset asserted in WAIT or RESP SHALL abort the request, and no response SHALL be emitted afterwards.
REQ-034 Writes presented while reset is 1 SHALL be dropped.

Configuration
REQ-035 Macro RESPONDER_STATS_EN, when defined, SHALL add output port req_count (32 bits), the number of accepted handshakes, saturating at 32'hFFFFFFFF and cleared by reset.
REQ-036 With RESPONDER_STATS_EN undefined, port req_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Latency 1: preload 16'h00AD = 16'hBEEF; request 16'hDEAD; addr_in_ready falls the next cycle; data_out_valid=1 with data_out=16'hBEEF one cycle after the handshake; IDLE the cycle after.
REQ-038 READ_LATENCY=3: request 16'hDEAD -> addr_in_ready=0 for 3 cycles; data_out_valid pulses exactly 3 cycles after the handshake; 16'hBEEF returned.
REQ-039 Back-to-back: valid held at 1, addresses 16'h0001 then 16'h0002 preloaded as 16'h1111/16'h2222 -> handshakes 2 cycles apart (latency 1); responses 16'h1111 then 16'h2222.
REQ-040 Collision: wr_en writes 16'hCAFE to index 16'hAD on the handshake edge of request 16'hDEAD -> response 16'hBEEF; a re-request returns 16'hCAFE.
REQ-041 Reset mid-WAIT (READ_LATENCY=3): reset asserted one cycle after the handshake -> data_out=0 and data_out_valid never pulses; a post-reset request to 16'hDEAD still returns 16'hBEEF.
REQ-042 With RESPONDER_STATS_EN defined: five handshakes -> req_count=5; after reset, req_count=0.

Source files
------------

// File: rtl/cache_memory_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cache_memory_responder
//
// Backing-store model that answers cache miss requests. A request is accepted
// only in IDLE; the addressed word is captured into a holding register on the
// handshake edge and presented with a one-cycle data_out_valid strobe
// READ_LATENCY cycles later. The store can be preloaded through the write
// port at any time outside reset. Reset never clears the store contents.
//
// Parameters
//   DWIDTH        data word width
//   ADDR_WIDTH    request / preload address width
//   MEM_ADDR_BITS log2 of store depth (low address bits index the store)
//   READ_LATENCY  cycles from handshake edge to response strobe (>= 1)
//
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous active-high reset
//   addr_in_valid  miss request valid
//   addr_in        miss request address
//   addr_in_ready  high only in IDLE
//   data_out       response word, held until the next response
//   data_out_valid one-cycle response strobe
//   wr_en          preload write enable
//   wr_addr        preload address
//   wr_data        preload data
//   req_count      (RESPONDER_STATS_EN only) saturating count of handshakes
//
// Build option: define RESPONDER_STATS_EN to add the req_count port.
// -----------------------------------------------------------------------------
module cache_memory_responder #(
   parameter int DWIDTH        = 16,
   parameter int ADDR_WIDTH    = 16,
   parameter int MEM_ADDR_BITS = 8,
   parameter int READ_LATENCY  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  addr_in_valid,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   output logic                  addr_in_ready,
   output logic [DWIDTH-1:0]     data_out,
   output logic                  data_out_valid,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0]     wr_data
`ifdef RESPONDER_STATS_EN
   ,
   output logic [31:0]           req_count
`endif
);

   localparam int DEPTH = 1 << MEM_ADDR_BITS;
   localparam int CNT_W = $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                   state_reg;
   logic [CNT_W-1:0]         cnt_reg;
   logic [DWIDTH-1:0]        hold_reg;   // word captured at the handshake
   logic [DWIDTH-1:0]        last_reg;   // last delivered word, shown between responses
   logic [DWIDTH-1:0]        mem [DEPTH];

   logic [MEM_ADDR_BITS-1:0] rd_idx;
   logic [MEM_ADDR_BITS-1:0] wr_idx;

   // Upper address bits intentionally alias onto the same store entries.
   logic                     unused_addr_bits;

   assign rd_idx           = addr_in[MEM_ADDR_BITS-1:0];
   assign wr_idx           = wr_addr[MEM_ADDR_BITS-1:0];
   assign unused_addr_bits = ^{addr_in, wr_addr};

   // The store write lives in the reset process so writes presented while
   // reset is high are dropped; the reset branch leaves the contents alone.
   // A same-edge write and handshake read see the pre-write word because
   // both are non-blocking updates of the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         hold_reg  <= '0;
         last_reg  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_idx] <= wr_data;
         end

         case (state_reg)
            IDLE: begin
               if (addr_in_valid) begin
                  hold_reg <= mem[rd_idx];
                  if (READ_LATENCY == 1) begin
                     state_reg <= RESP;
                  end else begin
                     state_reg <= WAIT;
                     cnt_reg   <= CNT_W'(READ_LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               // Counter value 1 marks the last WAIT cycle before RESP.
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg <= RESP;
               end
               cnt_reg <= cnt_reg - CNT_W'(1);
            end
            RESP: begin
               state_reg <= IDLE;
               last_reg  <= hold_reg;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // All outputs decode straight from registers; no input-to-output paths.
   assign addr_in_ready  = (state_reg == IDLE);
   assign data_out_valid = (state_reg == RESP);
   assign data_out       = (state_reg == RESP) ? hold_reg : last_reg;

`ifdef RESPONDER_STATS_EN
   logic [31:0] req_count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_count_reg <= '0;
      end else if (addr_in_valid && (state_reg == IDLE) && (req_count_reg != 32'hFFFF_FFFF)) begin
         req_count_reg <= req_count_reg + 32'd1;
      end
   end

   assign req_count = req_count_reg;
`endif

endmodule
